strobe_monitor: RTL

Receive-side checker for the periodic single-cycle strobe emitted by the strobe generator. It measures the interval between consecutive strobes and compares it against the expected period derived from the same `rate` setting. It declares lock after a run of correct intervals and flags early and late (missing) strobes. It sits next to the decimation/sample path and gives status and debug visibility into strobe cadence.

---
 rtl/strobe_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/strobe_monitor.sv
// -----------------------------------------------------------------------------
// strobe_monitor
//
// Receive-side checker for a periodic single-cycle strobe. It measures the
// interval between consecutive strobes and compares it against the expected
// period E = rate + 1, latched when the reference strobe is taken. After
// LOCK_COUNT consecutive good intervals it asserts locked. It flags early
// strobes (interval < E) and late/missing strobes (no strobe by interval E).
//
// Strobe semantics: strobe_in has no handshake. Every cycle on which strobe_in
// is high is one strobe event. There is no back-pressure, and the monitor
// samples strobe_in on every rising clock edge while enable is high.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : asynchronous, active-high; clears all state and outputs
//   enable     : synchronous run enable; low clears everything like reset
//   rate[7:0]  : divide setting; expected interval E = rate + 1 (1..256)
//   strobe_in  : strobe under test
//   locked     : high while the FSM is LOCKED (registered)
//   err_early  : one-cycle pulse, strobe arrived with interval < E
//   err_late   : one-cycle pulse, no strobe by interval E
//   err_count  : saturating count of early + late errors
//   period     : last measured interval, held until the next checked strobe
//   dbus       : {enable, state[1:0], strobe_in, locked, err_early, err_late,
//                 gap[8:0]}; enable and strobe_in are live, the rest registered
// -----------------------------------------------------------------------------
module strobe_monitor #(
    parameter int LOCK_COUNT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rate,
    input  logic        strobe_in,
    output logic        locked,
    output logic        err_early,
    output logic        err_late,
    output logic [15:0] err_count,
    output logic [8:0]  period,
    output logic [15:0] dbus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_TARGET = LOCK_COUNT[3:0];

    state_t      state, state_next;
    logic [8:0]  gap, gap_next;
    logic [8:0]  exp_period, exp_next;
    logic [3:0]  good, good_next;
    logic [8:0]  period_next;
    logic        early_next, late_next;
    logic [15:0] err_count_next;

    // Next-state and next-output logic. The enable clear is applied in the
    // register process so this block only describes the running behaviour.
    always_comb begin
        state_next  = state;
        exp_next    = exp_period;
        good_next   = good;
        period_next = period;
        early_next  = 1'b0;
        late_next   = 1'b0;

        // gap is 1 on the cycle after a strobe, so on a strobe cycle it holds
        // the interval since the previous strobe.
        if (strobe_in)
            gap_next = 9'd1;
        else if (gap == 9'h1FF)
            gap_next = gap;
        else
            gap_next = gap + 9'd1;

        case (state)
            IDLE: begin
                // Reference strobe: no check, just latch the expected period.
                if (strobe_in) begin
                    exp_next   = {1'b0, rate} + 9'd1;
                    good_next  = 4'd0;
                    state_next = ACQUIRE;
                end
            end
            ACQUIRE, LOCKED: begin
                if (strobe_in) begin
                    // A strobe on the gap == exp cycle is good; the strobe wins
                    // over the late check below.
                    period_next = gap;
                    if (gap == exp_period) begin
                        if (({1'b0, good} + 5'd1) >= {1'b0, LOCK_TARGET}) begin
                            good_next  = LOCK_TARGET;
                            state_next = LOCKED;
                        end else begin
                            good_next  = good + 4'd1;
                            state_next = ACQUIRE;
                        end
                    end else if (gap < exp_period) begin
                        // Early strobe becomes the new reference.
                        early_next = 1'b1;
                        good_next  = 4'd0;
                        state_next = ACQUIRE;
                    end else begin
                        // gap > exp cannot occur: the late check fires first.
                        good_next  = 4'd0;
                        state_next = IDLE;
                    end
                end else if (gap == exp_period) begin
                    late_next  = 1'b1;
                    good_next  = 4'd0;
                    state_next = IDLE;
                end
            end
            default: begin
                good_next  = 4'd0;
                state_next = IDLE;
            end
        endcase

        if ((early_next || late_next) && (err_count != 16'hFFFF))
            err_count_next = err_count + 16'd1;
        else
            err_count_next = err_count;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gap        <= 9'd0;
            exp_period <= 9'd0;
            good       <= 4'd0;
            period     <= 9'd0;
            err_count  <= 16'd0;
            locked     <= 1'b0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            gap        <= 9'd0;
            exp_period <= 9'd0;
            good       <= 4'd0;
            period     <= 9'd0;
            err_count  <= 16'd0;
            locked     <= 1'b0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
        end else begin
            state      <= state_next;
            gap        <= gap_next;
            exp_period <= exp_next;
            good       <= good_next;
            period     <= period_next;
            err_count  <= err_count_next;
            locked     <= (state_next == LOCKED);
            err_early  <= early_next;
            err_late   <= late_next;
        end
    end

    assign dbus = {enable, state, strobe_in, locked, err_early, err_late, gap};

endmodule
